// File: rtl/div_restoring_seq_if.sv
// Operand/result bundle for the sequential restoring divider.
// valid/ready: a transfer happens on a rising clk edge where valid && ready; a source holds valid
// (and its data) until that edge, and the sink may raise or lower ready at any time.
interface div_restoring_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  // Issuing unit / result consumer side.
  modport master (
    output in_valid, dividend, divisor, is_signed, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  // Divider side.
  modport slave (
    input  in_valid, dividend, divisor, is_signed, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_restoring_seq.sv
// Sequential restoring divider: one quotient bit per clock, optional two's-complement mode,
// divide-by-zero detection, valid/ready on both the operand and the result side.
module div_restoring_seq #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  div_restoring_seq_if.slave  bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] dvd_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic             out_valid_q;
  logic             dbz_q;

  logic             accept;
  logic             signed_op;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   a_sh;
  logic [WIDTH:0]   diff;
  logic             restore;
  logic [WIDTH-1:0] a_nx;
  logic [WIDTH-1:0] q_nx;
  logic             last_iter;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign bus.in_ready    = (state_q == IDLE) && rst_n;
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign dbg_state       = state_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign signed_op = SIGNED_EN && bus.is_signed;
  assign dvd_mag   = (signed_op && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
  assign dvs_mag   = (signed_op && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

  // The shifted partial remainder needs WIDTH+1 bits because M can be as large as 2^WIDTH-1.
  // Since a_sh < 2*M, bit WIDTH of the (WIDTH+1)-bit difference is set exactly when a_sh < M.
  assign a_sh      = {a_q, q_q[WIDTH-1]};
  assign diff      = a_sh - {1'b0, m_q};
  assign restore   = diff[WIDTH];
  assign a_nx      = restore ? a_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign q_nx      = {q_q[WIDTH-2:0], ~restore};
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // Quotient sign is the XOR of operand signs; remainder sign follows the dividend.
  assign quo_fix = neg_quo_q ? -q_q : q_q;
  assign rem_fix = neg_rem_q ? -a_q : a_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = (bus.divisor == '0) ? DONE : ITER;
      end
      ITER: begin
        if (last_iter) state_d = FIXUP;
      end
      FIXUP: state_d = DONE;
      DONE: begin
        if (out_valid_q && bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      dvd_q       <= '0;
      cnt_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            dvd_q     <= bus.dividend;
            m_q       <= dvs_mag;
            q_q       <= dvd_mag;
            a_q       <= '0;
            cnt_q     <= '0;
            neg_quo_q <= signed_op && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            neg_rem_q <= signed_op && bus.dividend[WIDTH-1];
            dbz_q     <= 1'b0;
          end
        end
        ITER: begin
          a_q   <= a_nx;
          q_q   <= q_nx;
          cnt_q <= cnt_q + CW'(1);
        end
        FIXUP: begin
          quo_q       <= quo_fix;
          rem_q       <= rem_fix;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          // DONE is only entered with out_valid low on the divide-by-zero path.
          if (!out_valid_q) begin
            quo_q       <= '1;
            rem_q       <= dvd_q;
            dbz_q       <= 1'b1;
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_restoring_seq.sv
// Self-checking bench for div_restoring_seq (WIDTH=8, SIGNED_EN=1): directed corner cases,
// backpressure, mid-operation reset and randomized traffic against an arithmetic reference.
module tb_div_restoring_seq;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         failures = 0;
  logic [2*W:0] exp_q[$];

  div_restoring_seq_if #(.WIDTH(W)) dif();

  div_restoring_seq #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (dif),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  // Reference: C-style truncating division; remainder takes the dividend's sign.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    int sa, sb;
    if (b == '0) begin
      q = '1; r = a; z = 1'b1;
    end else if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      q = W'(sa / sb); r = W'(sa % sb); z = 1'b0;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    dif.in_valid = 1'b1; dif.dividend = a; dif.divisor = b; dif.is_signed = s;
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    dif.dividend = W'($urandom); dif.divisor = W'($urandom); dif.is_signed = 1'($urandom);
  endtask

  task automatic wait_valid(output int lat, output bit busy_ok);
    lat = 0; busy_ok = 1'b1;
    while (dif.out_valid !== 1'b1 && lat < 40) begin
      if (dif.in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    dif.out_ready = 1'b1;
    @(posedge clk); #1;
    dif.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    dif.in_valid = 1'b1; dif.dividend = 8'd9; dif.divisor = 8'd3; dif.is_signed = 1'b0;
    dif.out_ready = 1'b0; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dif.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", dif.in_ready); end
    checks++; if (dif.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", dif.out_valid); end
    checks++; if (dif.quotient !== 8'h00) begin failures++; $display("FAIL rst_quotient got=%h exp=00", dif.quotient); end
    checks++; if (dif.remainder !== 8'h00) begin failures++; $display("FAIL rst_remainder got=%h exp=00", dif.remainder); end
    checks++; if (dif.div_by_zero !== 1'b0) begin failures++; $display("FAIL rst_dbz got=%b exp=0", dif.div_by_zero); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
    dif.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++; if (dif.in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_in_ready got=%b exp=1", dif.in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_divide();
    vec_t tbl[6];
    int lat; bit busy_ok;
    tbl[0] = '{8'd100, 8'd7,  1'b0, 8'd14, 8'd2,  1'b0, 9};
    tbl[1] = '{8'hF9,  8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0, 9};
    tbl[2] = '{8'h07,  8'hFE, 1'b1, 8'hFD, 8'h01, 1'b0, 9};
    tbl[3] = '{8'h80,  8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 9};
    tbl[4] = '{8'hFF,  8'h01, 1'b0, 8'hFF, 8'h00, 1'b0, 9};
    tbl[5] = '{8'd200, 8'd13, 1'b0, 8'd15, 8'd5,  1'b0, 9};
    for (int i = 0; i < 6; i++) begin
      checks++; if (dif.in_ready !== 1'b1) begin failures++; $display("FAIL div_idle_ready[%0d] got=%b exp=1", i, dif.in_ready); end
      issue(tbl[i].a, tbl[i].b, tbl[i].s);
      wait_valid(lat, busy_ok);
      checks++; if (lat != tbl[i].lat) begin failures++; $display("FAIL div_latency[%0d] got=%0d exp=%0d", i, lat, tbl[i].lat); end
      checks++; if (!busy_ok) begin failures++; $display("FAIL div_busy_ready[%0d] got=1 exp=0", i); end
      checks++; if (dif.quotient !== tbl[i].q) begin failures++; $display("FAIL div_q[%0d] got=%h exp=%h", i, dif.quotient, tbl[i].q); end
      checks++; if (dif.remainder !== tbl[i].r) begin failures++; $display("FAIL div_r[%0d] got=%h exp=%h", i, dif.remainder, tbl[i].r); end
      checks++; if (dif.div_by_zero !== tbl[i].z) begin failures++; $display("FAIL div_dbz[%0d] got=%b exp=%b", i, dif.div_by_zero, tbl[i].z); end
      consume();
    end
  endtask

  task automatic test_div_by_zero();
    int lat; bit busy_ok;
    for (int s = 0; s < 2; s++) begin
      issue(8'h2A, 8'h00, 1'(s));
      checks++; if (dif.div_by_zero !== 1'b0) begin failures++; $display("FAIL dbz_cleared_on_accept[%0d] got=%b exp=0", s, dif.div_by_zero); end
      wait_valid(lat, busy_ok);
      checks++; if (lat != 1) begin failures++; $display("FAIL dbz_latency[%0d] got=%0d exp=1", s, lat); end
      checks++; if (dif.quotient !== 8'hFF) begin failures++; $display("FAIL dbz_q[%0d] got=%h exp=ff", s, dif.quotient); end
      checks++; if (dif.remainder !== 8'h2A) begin failures++; $display("FAIL dbz_r[%0d] got=%h exp=2a", s, dif.remainder); end
      checks++; if (dif.div_by_zero !== 1'b1) begin failures++; $display("FAIL dbz_flag[%0d] got=%b exp=1", s, dif.div_by_zero); end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat; bit busy_ok;
    logic [W-1:0] eq, er; logic ez;
    model(8'hF9, 8'h02, 1'b1, eq, er, ez);
    issue(8'hF9, 8'h02, 1'b1);
    wait_valid(lat, busy_ok);
    for (int i = 0; i < 5; i++) begin
      dif.in_valid = 1'b1; dif.dividend = W'($urandom); dif.divisor = W'($urandom); dif.is_signed = 1'($urandom);
      @(posedge clk); #1;
      checks++; if (dif.out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid[%0d] got=%b exp=1", i, dif.out_valid); end
      checks++; if (dif.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, dif.in_ready); end
      checks++; if ({dif.quotient, dif.remainder, dif.div_by_zero} !== {eq, er, ez}) begin
        failures++; $display("FAIL bp_stable[%0d] got=%h/%h/%b exp=%h/%h/%b", i, dif.quotient, dif.remainder, dif.div_by_zero, eq, er, ez);
      end
    end
    dif.in_valid = 1'b0;
    consume();
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL bp_idle_state got=%0d exp=0", dbg_state); end
    checks++; if (dif.in_ready !== 1'b1) begin failures++; $display("FAIL bp_idle_ready got=%b exp=1", dif.in_ready); end
    repeat (3) begin
      @(posedge clk); #1;
      checks++; if (dif.out_valid !== 1'b0 || dif.quotient !== eq) begin
        failures++; $display("FAIL bp_no_phantom got=%b/%h exp=0/%h", dif.out_valid, dif.quotient, eq);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int lat; bit busy_ok; bit seen;
    issue(8'd100, 8'd7, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++; if (dif.in_ready !== 1'b1) begin failures++; $display("FAIL abort_in_ready got=%b exp=1", dif.in_ready); end
    checks++; if (dif.quotient !== 8'h00) begin failures++; $display("FAIL abort_q_cleared got=%h exp=00", dif.quotient); end
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (dif.out_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin failures++; $display("FAIL abort_no_result got=1 exp=0"); end
    issue(8'd200, 8'd13, 1'b0);
    wait_valid(lat, busy_ok);
    checks++; if ({dif.quotient, dif.remainder} !== {8'd15, 8'd5}) begin
      failures++; $display("FAIL abort_next_op got=%0d/%0d exp=15/5", dif.quotient, dif.remainder);
    end
    consume();
  endtask

  task automatic test_random();
    int lat; bit busy_ok;
    logic [W-1:0] a, b, eq, er; logic s, ez;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom); b = W'($urandom); s = 1'($urandom);
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 7) == 0) a = 8'h80;
      if ($urandom_range(0, 7) == 0) b = 8'hFF;
      model(a, b, s, eq, er, ez);
      issue(a, b, s);
      wait_valid(lat, busy_ok);
      checks++; if (lat != ((b == '0) ? 1 : W + 1)) begin failures++; $display("FAIL rand_latency[%0d] got=%0d a=%h b=%h", i, lat, a, b); end
      checks++; if ({dif.quotient, dif.remainder, dif.div_by_zero} !== {eq, er, ez}) begin
        failures++; $display("FAIL rand_result[%0d] a=%h b=%h s=%b got=%h/%h/%b exp=%h/%h/%b", i, a, b, s,
                             dif.quotient, dif.remainder, dif.div_by_zero, eq, er, ez);
      end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 30;
    int n_acc = 0, n_out = 0, cyc = 0;
    bit fire_in, fire_out;
    logic [W-1:0] a, b, eq, er, gq, gr; logic s, ez, gz;
    logic [2*W:0] e;
    dif.in_valid = 1'b0;
    while ((n_acc < N || exp_q.size() > 0) && cyc < 3000) begin
      if (!dif.in_valid && n_acc < N) begin
        a = W'($urandom); b = W'($urandom_range(0, 3) == 0 ? 0 : $urandom); s = 1'($urandom);
        dif.dividend = a; dif.divisor = b; dif.is_signed = s; dif.in_valid = 1'b1;
      end
      dif.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      fire_in  = dif.in_valid && dif.in_ready;
      fire_out = dif.out_valid && dif.out_ready;
      gq = dif.quotient; gr = dif.remainder; gz = dif.div_by_zero;
      @(posedge clk); #1;
      cyc++;
      if (fire_in) begin
        model(a, b, s, eq, er, ez);
        exp_q.push_back({eq, er, ez});
        n_acc++;
        dif.in_valid = 1'b0;
      end
      if (fire_out) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_out++;
        checks++; if ({gq, gr, gz} !== e) begin failures++; $display("FAIL b2b_result[%0d] got=%h/%h/%b exp=%h", n_out, gq, gr, gz, e); end
      end
    end
    dif.in_valid = 1'b0; dif.out_ready = 1'b0;
    checks++; if (n_out != N) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", n_out, N); end
  endtask

  initial begin
    dif.in_valid = 1'b0; dif.dividend = '0; dif.divisor = '0; dif.is_signed = 1'b0; dif.out_ready = 1'b0;
    test_reset();
    test_divide();
    test_div_by_zero();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
